// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU SPI front end: frame state encoding and
// target codes carried in the first byte of every frame.
package mcu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TARGET = 2'd1,
    CMD    = 2'd2,
    DATA   = 2'd3
  } state_t;

  localparam logic [7:0] TGT_SYS = 8'd1;
  localparam logic [7:0] TGT_HID = 8'd2;
  localparam logic [7:0] TGT_OSD = 8'd3;
  localparam logic [7:0] TGT_SDC = 8'd4;

  function automatic logic tgt_valid(input logic [7:0] tgt);
    return (tgt >= TGT_SYS) && (tgt <= TGT_SDC);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, with single-cycle
// rise/fall indications derived from the synchronised level.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= {STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign q    = sync_r[STAGES-1];
  assign rise = sync_r[STAGES-1] & ~prev_r;
  assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/mcu_spi.sv
// SPI mode-0 slave front end: deframes MCU bytes in the clk domain, routes
// them to one of four targets as strobes and shifts replies back one byte late.
module mcu_spi
  import mcu_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic       mcu_start,
  output logic [7:0] mcu_dout,
  output logic       mcu_sys_strobe,
  output logic       mcu_hid_strobe,
  output logic       mcu_osd_strobe,
  output logic       mcu_sdc_strobe,
  input  logic [7:0] mcu_sys_din,
  input  logic [7:0] mcu_hid_din,
  input  logic [7:0] mcu_osd_din,
  input  logic [7:0] mcu_sdc_din
);

  logic ss_q, ss_rise, ss_fall;
  logic sck_q, sck_rise, sck_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic mosi_q;

  state_t     state_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] rx_r;
  logic [7:0] tx_r;
  logic [7:0] tgt_r;
  logic       byte_done_r;
  logic       load_pend_r;
  logic       reply_ok_r;
  logic [7:0] reply_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk  (clk),
    .reset(reset),
    .din  (spi_io_ss),
    .q    (ss_q),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk  (clk),
    .reset(reset),
    .din  (spi_io_clk),
    .q    (sck_q),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // MOSI synchroniser, same depth as SCK so data and edge stay aligned.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_io_din};
    end
  end

  assign mosi_q      = mosi_sync_r[SYNC_STAGES-1];
  assign spi_io_dout = tx_r[7];

  // Reply byte of the currently selected target.
  always_comb begin
    reply_s = 8'h00;
    case (tgt_r)
      TGT_SYS: reply_s = mcu_sys_din;
      TGT_HID: reply_s = mcu_hid_din;
      TGT_OSD: reply_s = mcu_osd_din;
      TGT_SDC: reply_s = mcu_sdc_din;
      default: reply_s = 8'h00;
    endcase
  end

  // Deframer, frame state machine, strobe generation and MISO shifter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= IDLE;
      bit_cnt_r      <= 3'd0;
      rx_r           <= 8'h00;
      tx_r           <= 8'h00;
      tgt_r          <= 8'h00;
      byte_done_r    <= 1'b0;
      load_pend_r    <= 1'b0;
      reply_ok_r     <= 1'b0;
      mcu_dout       <= 8'h00;
      mcu_start      <= 1'b0;
      mcu_sys_strobe <= 1'b0;
      mcu_hid_strobe <= 1'b0;
      mcu_osd_strobe <= 1'b0;
      mcu_sdc_strobe <= 1'b0;
    end else begin
      mcu_start      <= 1'b0;
      mcu_sys_strobe <= 1'b0;
      mcu_hid_strobe <= 1'b0;
      mcu_osd_strobe <= 1'b0;
      mcu_sdc_strobe <= 1'b0;
      byte_done_r    <= 1'b0;
      if (ss_q || ss_rise) begin
        // SS high aborts any partial byte; SCK edges this cycle are ignored.
        state_r     <= IDLE;
        bit_cnt_r   <= 3'd0;
        tx_r        <= 8'h00;
        load_pend_r <= 1'b0;
      end else if (state_r == IDLE) begin
        // A frame only begins on a seen SS falling edge, so SS held low out of reset is ignored.
        bit_cnt_r <= 3'd0;
        if (ss_fall) begin
          state_r <= TARGET;
        end else begin
          state_r <= IDLE;
        end
      end else begin
        if (sck_rise) begin
          rx_r        <= {rx_r[6:0], mosi_q};
          bit_cnt_r   <= bit_cnt_r + 3'd1;
          byte_done_r <= (bit_cnt_r == 3'd7);
        end
        if (byte_done_r) begin
          load_pend_r <= 1'b1;
          case (state_r)
            TARGET: begin
              tgt_r      <= rx_r;
              reply_ok_r <= 1'b0;
              state_r    <= CMD;
            end
            CMD, DATA: begin
              mcu_dout   <= rx_r;
              reply_ok_r <= tgt_valid(tgt_r);
              mcu_start  <= (state_r == CMD) && tgt_valid(tgt_r);
              case (tgt_r)
                TGT_SYS: mcu_sys_strobe <= 1'b1;
                TGT_HID: mcu_hid_strobe <= 1'b1;
                TGT_OSD: mcu_osd_strobe <= 1'b1;
                TGT_SDC: mcu_sdc_strobe <= 1'b1;
                default: mcu_start      <= 1'b0;
              endcase
              state_r <= DATA;
            end
            default: state_r <= IDLE;
          endcase
        end
        // First falling edge after a byte loads the reply; later ones shift it.
        if (sck_fall) begin
          if (load_pend_r) begin
            tx_r        <= reply_ok_r ? reply_s : 8'h00;
            load_pend_r <= 1'b0;
          end else begin
            tx_r <= {tx_r[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
